// File: rtl/sc_demap_pp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_demap_pp_pkg : shared sizes, index-map constants and read FSM states
// Revision 1.0
// ---------------------------------------------------------------------------
package sc_demap_pp_pkg;

  localparam int N_BIN  = 256;
  localparam int OSR    = 4;
  localparam int N_SC   = 64;
  localparam int N_USED = 52;

  localparam int K_W   = $clog2(N_BIN);
  localparam int OSR_W = $clog2(OSR);
  localparam int A_W   = $clog2(N_SC);

  localparam logic [K_W-1:0] K_LAST  = K_W'(N_BIN - 1);
  localparam logic [A_W-1:0] J_LAST  = A_W'(N_USED - 1);
  localparam logic [A_W-1:0] J_SPLIT = A_W'(N_USED / 2 - 1);

  // Negative subcarriers live in the upper half of the slot grid
  localparam logic [A_W-1:0] MAP_NEG_OFS = 6'd38;
  localparam logic [A_W-1:0] MAP_POS_OFS = 6'd25;

  localparam logic [A_W-1:0] PLT_J0 = 6'd5;
  localparam logic [A_W-1:0] PLT_J1 = 6'd19;
  localparam logic [A_W-1:0] PLT_J2 = 6'd32;
  localparam logic [A_W-1:0] PLT_J3 = 6'd46;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/sc_demap_pp_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_demap_pp_if : upstream bin stream and downstream subcarrier stream
// Revision 1.0
// ---------------------------------------------------------------------------
interface sc_demap_pp_if;
  logic [31:0] DAT_I;
  logic        WE_I;
  logic        STB_I;
  logic        CYC_I;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        PLT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;

  modport slave (
    input  DAT_I, WE_I, STB_I, CYC_I, ACK_I,
    output ACK_O, DAT_O, PLT_O, CYC_O, STB_O, WE_O
  );

  modport master (
    output DAT_I, WE_I, STB_I, CYC_I, ACK_I,
    input  ACK_O, DAT_O, PLT_O, CYC_O, STB_O, WE_O
  );
endinterface
`default_nettype wire

// File: rtl/sc_demap_pp_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_pp_ram : dual-bank ping-pong RAM, one write port, one sync read port
// Revision 1.0
// ---------------------------------------------------------------------------
module sc_pp_ram
  import sc_demap_pp_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           i_we,
  input  wire logic           i_wbank,
  input  wire logic [A_W-1:0] i_waddr,
  input  wire logic [31:0]    i_wdata,
  input  wire logic           i_re,
  input  wire logic           i_rbank,
  input  wire logic [A_W-1:0] i_raddr,
  output      logic [31:0]    o_rdata
);

  logic [31:0] r_mem [0:2*N_SC-1];

  // Read data holds while i_re is low so a stalled consumer keeps its word
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[{i_wbank, i_waddr}] <= i_wdata;
    if (i_re)
      o_rdata <= r_mem[{i_rbank, i_raddr}];
  end

endmodule
`default_nettype wire

// File: rtl/sc_demap_pp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_demap_pp : extracts the 52 used subcarriers of a 256-bin symbol into a
//               ping-pong buffer and re-emits them in logical order
// Revision 1.0
// ---------------------------------------------------------------------------
module sc_demap_pp
  import sc_demap_pp_pkg::*;
(
  input  wire logic    CLK_I,
  input  wire logic    RST_I,
  sc_demap_pp_if.slave bus
);

  logic           r_cyc_d;
  logic [K_W-1:0] r_k;
  logic [1:0]     r_bank_full;
  logic           r_wr_bank;
  logic           r_rd_bank;
  rd_state_t      r_state;
  logic [A_W-1:0] r_j;
  logic           r_a_val, r_a_plt, r_a_last;
  logic           r_stb, r_plt, r_o_last, r_cyc_o;
  logic [31:0]    r_dat;

  logic           w_istart, w_datin_val, w_ack, w_wr_bank;
  logic           w_ram_we, w_sym_done;
  logic           w_out_halt, w_issue, w_last_hs, w_plt;
  logic [K_W-1:0] w_k;
  logic [A_W-1:0] w_m;
  logic [31:0]    w_rdata;

  assign w_istart    = bus.CYC_I & ~r_cyc_d;
  assign w_datin_val = bus.CYC_I & bus.STB_I & bus.WE_I;
  assign w_ack       = w_datin_val & ~r_bank_full[r_wr_bank];
  // A beat accepted on the frame-start cycle already sees the cleared counters
  assign w_k         = w_istart ? '0 : r_k;
  assign w_wr_bank   = w_istart ? 1'b0 : r_wr_bank;
  assign w_ram_we    = w_ack & (w_k[OSR_W-1:0] == '0);
  assign w_sym_done  = w_ack & (w_k == K_LAST);

  assign w_out_halt = r_stb & ~bus.ACK_I;
  assign w_issue    = (r_state == RD_ISSUE) & ~w_out_halt;
  assign w_last_hs  = r_stb & bus.ACK_I & r_o_last;
  assign w_m        = (r_j <= J_SPLIT) ? r_j + MAP_NEG_OFS : r_j - MAP_POS_OFS;
  assign w_plt      = (r_j == PLT_J0) | (r_j == PLT_J1) | (r_j == PLT_J2) | (r_j == PLT_J3);

  sc_pp_ram u_ram (
    .clk     (CLK_I),
    .i_we    (w_ram_we),
    .i_wbank (w_wr_bank),
    .i_waddr (w_k[K_W-1:OSR_W]),
    .i_wdata (bus.DAT_I),
    .i_re    (w_issue),
    .i_rbank (r_rd_bank),
    .i_raddr (w_m),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_cyc_d   <= 1'b1;
      r_k       <= '0;
      r_wr_bank <= 1'b0;
    end else begin
      r_cyc_d <= bus.CYC_I;
      if (w_istart || w_ack) begin
        r_k       <= w_ack ? w_k + 1'b1 : w_k;
        r_wr_bank <= w_wr_bank ^ w_sym_done;
      end
    end
  end

  // Read FSM with a two-stage output pipeline (RAM read, output register)
  // that advances as a whole whenever the output is not halted.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_bank_full <= '0;
      r_rd_bank   <= 1'b0;
      r_state     <= RD_IDLE;
      r_j         <= '0;
      r_a_val     <= 1'b0;
      r_a_plt     <= 1'b0;
      r_a_last    <= 1'b0;
      r_stb       <= 1'b0;
      r_dat       <= '0;
      r_plt       <= 1'b0;
      r_o_last    <= 1'b0;
      r_cyc_o     <= 1'b0;
    end else if (w_istart) begin
      r_bank_full <= '0;
      r_rd_bank   <= 1'b0;
      r_state     <= RD_IDLE;
      r_j         <= '0;
      r_a_val     <= 1'b0;
      r_stb       <= 1'b0;
      r_cyc_o     <= 1'b1;
    end else begin
      if (w_sym_done)
        r_bank_full[r_wr_bank] <= 1'b1;
      if (w_last_hs)
        r_bank_full[r_rd_bank] <= 1'b0;

      case (r_state)
        RD_IDLE: begin
          if (r_bank_full[r_rd_bank]) begin
            r_state <= RD_ISSUE;
            r_j     <= '0;
          end
        end
        RD_ISSUE: begin
          if (w_issue) begin
            if (r_j == J_LAST)
              r_state <= RD_DRAIN;
            r_j <= r_j + 1'b1;
          end
        end
        RD_DRAIN: begin
          if (w_last_hs) begin
            r_state   <= RD_IDLE;
            r_rd_bank <= ~r_rd_bank;
          end
        end
        default: r_state <= RD_IDLE;
      endcase

      if (!w_out_halt) begin
        r_a_val  <= w_issue;
        r_a_plt  <= w_plt;
        r_a_last <= (r_j == J_LAST);
        r_stb    <= r_a_val;
        if (r_a_val) begin
          r_dat    <= w_rdata;
          r_plt    <= r_a_plt;
          r_o_last <= r_a_last;
        end
      end

      if (r_cyc_o && !bus.CYC_I && (r_bank_full == '0) && (r_state == RD_IDLE) && !r_stb)
        r_cyc_o <= 1'b0;
    end
  end

  assign bus.ACK_O = w_ack;
  assign bus.DAT_O = r_dat;
  assign bus.PLT_O = r_plt;
  assign bus.STB_O = r_stb;
  assign bus.CYC_O = r_cyc_o;
  assign bus.WE_O  = r_cyc_o;

endmodule
`default_nettype wire

// File: tb/tb_sc_demap_pp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sc_demap_pp : scoreboard bench for the subcarrier demapper
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sc_demap_pp;

  logic CLK_I = 1'b0;
  logic RST_I;
  sc_demap_pp_if bus ();

  sc_demap_pp dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .bus   (bus)
  );

  always #5 CLK_I = ~CLK_I;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          n_plt_seen = 0;
  int          n_hold = 0;
  logic [32:0] sb [$];
  logic [32:0] mon_exp;
  bit          mon_prev_halt = 1'b0;
  logic [31:0] prev_dat;
  logic        prev_plt;
  bit          rand_ack = 1'b0;

  always @(posedge CLK_I) begin
    #1;
    if (rand_ack) bus.ACK_I = 1'($urandom_range(0, 1));
  end

  // Output monitor: handshake pops the scoreboard, a halted word must hold
  always @(negedge CLK_I) begin
    if (RST_I) begin
      mon_prev_halt = 1'b0;
    end else begin
      if (mon_prev_halt) begin
        n_cmp++;
        n_hold++;
        if (bus.STB_O !== 1'b1 || bus.DAT_O !== prev_dat || bus.PLT_O !== prev_plt) begin
          n_err++;
          $display("FAIL hold_stable: got STB_O=%b DAT_O=%h PLT_O=%b, want STB_O=1 DAT_O=%h PLT_O=%b",
                   bus.STB_O, bus.DAT_O, bus.PLT_O, prev_dat, prev_plt);
        end
      end
      if (bus.STB_O === 1'b1 && bus.ACK_I === 1'b1) begin
        n_cmp++;
        n_pop++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL extra_output: got DAT_O=%h PLT_O=%b, want no output", bus.DAT_O, bus.PLT_O);
        end else begin
          mon_exp = sb.pop_front();
          if ({bus.PLT_O, bus.DAT_O} !== mon_exp) begin
            n_err++;
            $display("FAIL sb_word: got PLT_O=%b DAT_O=%h, want PLT_O=%b DAT_O=%h",
                     bus.PLT_O, bus.DAT_O, mon_exp[32], mon_exp[31:0]);
          end
          if (bus.PLT_O === 1'b1) n_plt_seen++;
        end
      end
      mon_prev_halt = (bus.STB_O === 1'b1) && (bus.ACK_I !== 1'b1);
      prev_dat      = bus.DAT_O;
      prev_plt      = bus.PLT_O;
    end
  end

  // Expected order: sc = -26..-1, +1..+26; sc lands in slot sc mod 64, bin 4*slot
  task automatic push_symbol(input logic [15:0] tag);
    for (int j = 0; j < 52; j++) begin
      int   sc;
      int   slot;
      logic p;
      sc   = (j < 26) ? j - 26 : j - 25;
      slot = (sc < 0) ? sc + 64 : sc;
      p    = (sc == 7) || (sc == -7) || (sc == 21) || (sc == -21);
      sb.push_back({p, tag, 16'(slot * 4)});
    end
  endtask

  task automatic feed(input int nbeats, input logic [15:0] tag, input bit push,
                      output int stalls, output bit tmo);
    int wait_cnt;
    bit acc;
    stalls   = 0;
    tmo      = 1'b0;
    bus.CYC_I = 1'b1;
    bus.WE_I  = 1'b1;
    for (int k = 0; k < nbeats && !tmo; k++) begin
      bus.DAT_I = {tag, 8'h00, 8'(k)};
      bus.STB_I = 1'b1;
      wait_cnt  = 0;
      acc       = 1'b0;
      while (!acc && !tmo) begin
        @(negedge CLK_I);
        acc = bus.ACK_O;
        if (!acc) begin
          stalls++;
          wait_cnt++;
          if (wait_cnt > 400) tmo = 1'b1;
          @(posedge CLK_I);
          #1;
        end
      end
      if (acc) begin
        @(posedge CLK_I);
        #1;
        if (push && k == 255) push_symbol(tag);
      end
    end
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge CLK_I);
      if (sb.size() == 0) ok = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset;
    RST_I     = 1'b1;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.DAT_I = '0;
    bus.ACK_I = 1'b1;
    repeat (3) @(posedge CLK_I);
    #1;
    n_cmp++;
    if ({bus.STB_O, bus.CYC_O, bus.WE_O, bus.PLT_O} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got STB/CYC/WE/PLT=%b%b%b%b, want 0000",
               bus.STB_O, bus.CYC_O, bus.WE_O, bus.PLT_O);
    end
    n_cmp++;
    if (bus.DAT_O !== 32'h0) begin
      n_err++;
      $display("FAIL reset_dat: got %h, want 00000000", bus.DAT_O);
    end
    RST_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
  endtask

  task automatic test_single_symbol(input logic [15:0] tag);
    int st, lat, plt0;
    bit tmo, ok;
    plt0 = n_plt_seen;
    feed(256, tag, 1'b1, st, tmo);
    n_cmp++;
    if (tmo || st != 0) begin
      n_err++;
      $display("FAIL single_ack: got stalls=%0d timeout=%0d, want 0 0", st, tmo);
    end
    n_cmp++;
    if (bus.CYC_O !== 1'b1) begin
      n_err++;
      $display("FAIL single_cyc_open: got CYC_O=%b, want 1", bus.CYC_O);
    end
    lat = 0;
    while (bus.STB_O !== 1'b1 && lat < 10) begin
      @(posedge CLK_I);
      #1;
      lat++;
    end
    n_cmp++;
    if (bus.STB_O !== 1'b1 || lat > 3) begin
      n_err++;
      $display("FAIL first_latency: got %0d cycles, want <= 3", lat);
    end
    bus.CYC_I = 1'b0;
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL single_drain: got %0d words left, want 0", sb.size());
    end
    n_cmp++;
    if (n_plt_seen - plt0 != 4) begin
      n_err++;
      $display("FAIL single_pilots: got %0d, want 4", n_plt_seen - plt0);
    end
    @(posedge CLK_I);
    #1;
    n_cmp++;
    if (bus.CYC_O !== 1'b0 || bus.STB_O !== 1'b0) begin
      n_err++;
      $display("FAIL single_close: got CYC_O=%b STB_O=%b, want 0 0", bus.CYC_O, bus.STB_O);
    end
  endtask

  task automatic test_back_to_back;
    int st, tot, pop0;
    bit tmo, t, ok;
    tot  = 0;
    tmo  = 1'b0;
    pop0 = n_pop;
    for (int s = 1; s <= 3; s++) begin
      feed(256, 16'(s), 1'b1, st, t);
      tot += st;
      tmo |= t;
    end
    bus.CYC_I = 1'b0;
    n_cmp++;
    if (tmo || tot != 0) begin
      n_err++;
      $display("FAIL b2b_ack: got stalls=%0d timeout=%0d, want 0 0", tot, tmo);
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok || n_pop - pop0 != 156) begin
      n_err++;
      $display("FAIL b2b_count: got %0d outputs, want 156", n_pop - pop0);
    end
    @(posedge CLK_I);
    #1;
    n_cmp++;
    if (bus.CYC_O !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_close: got CYC_O=%b, want 0", bus.CYC_O);
    end
  endtask

  task automatic test_stall;
    int st, tot;
    bit tmo, t, ok;
    tot = 0;
    tmo = 1'b0;
    bus.ACK_I = 1'b0;
    feed(256, 16'h0004, 1'b1, st, t);
    tot += st; tmo |= t;
    feed(256, 16'h0005, 1'b1, st, t);
    tot += st; tmo |= t;
    n_cmp++;
    if (tmo || tot != 0) begin
      n_err++;
      $display("FAIL stall_fill: got stalls=%0d timeout=%0d, want 0 0", tot, tmo);
    end
    bus.DAT_I = {16'h0006, 16'h0000};
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    repeat (5) @(negedge CLK_I);
    n_cmp++;
    if (bus.ACK_O !== 1'b0 || bus.STB_O !== 1'b1) begin
      n_err++;
      $display("FAIL stall_ack: got ACK_O=%b STB_O=%b, want 0 1", bus.ACK_O, bus.STB_O);
    end
    @(posedge CLK_I);
    #1;
    bus.ACK_I = 1'b1;
    feed(256, 16'h0006, 1'b1, st, tmo);
    n_cmp++;
    if (tmo) begin
      n_err++;
      $display("FAIL stall_resume: got timeout=%0d, want 0", tmo);
    end
    bus.CYC_I = 1'b0;
    wait_drain(ok);
    @(posedge CLK_I);
    #1;
    n_cmp++;
    if (!ok || bus.CYC_O !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain: got left=%0d CYC_O=%b, want 0 0", sb.size(), bus.CYC_O);
    end
  endtask

  task automatic test_random_ack;
    int st, hold0;
    bit tmo, t, ok;
    hold0    = n_hold;
    rand_ack = 1'b1;
    feed(256, 16'h0007, 1'b1, st, tmo);
    feed(256, 16'h0008, 1'b1, st, t);
    tmo |= t;
    bus.CYC_I = 1'b0;
    wait_drain(ok);
    rand_ack = 1'b0;
    @(posedge CLK_I);
    #2;
    bus.ACK_I = 1'b1;
    n_cmp++;
    if (tmo || !ok) begin
      n_err++;
      $display("FAIL rand_drain: got timeout=%0d left=%0d, want 0 0", tmo, sb.size());
    end
    n_cmp++;
    if (n_hold - hold0 == 0) begin
      n_err++;
      $display("FAIL rand_holds: got %0d halted cycles, want > 0", n_hold - hold0);
    end
  endtask

  task automatic test_partial;
    int st;
    bit tmo, ok;
    feed(100, 16'h00AA, 1'b0, st, tmo);
    bus.CYC_I = 1'b0;
    repeat (10) @(posedge CLK_I);
    #1;
    n_cmp++;
    if (bus.CYC_O !== 1'b0 || bus.STB_O !== 1'b0) begin
      n_err++;
      $display("FAIL partial_close: got CYC_O=%b STB_O=%b, want 0 0", bus.CYC_O, bus.STB_O);
    end
    feed(256, 16'h0009, 1'b1, st, tmo);
    bus.CYC_I = 1'b0;
    wait_drain(ok);
    @(posedge CLK_I);
    #1;
    n_cmp++;
    if (tmo || !ok || bus.CYC_O !== 1'b0) begin
      n_err++;
      $display("FAIL partial_restart: got timeout=%0d left=%0d CYC_O=%b, want 0 0 0",
               tmo, sb.size(), bus.CYC_O);
    end
  endtask

  task automatic test_async_reset;
    int st;
    bit tmo;
    feed(256, 16'h000A, 1'b1, st, tmo);
    bus.CYC_I = 1'b0;
    repeat (10) @(posedge CLK_I);
    @(negedge CLK_I);
    #2;
    RST_I = 1'b1;
    #1;
    n_cmp++;
    if ({bus.STB_O, bus.CYC_O, bus.PLT_O} !== 3'b000 || bus.DAT_O !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got STB/CYC/PLT=%b%b%b DAT_O=%h, want 000 00000000",
               bus.STB_O, bus.CYC_O, bus.PLT_O, bus.DAT_O);
    end
    sb.delete();
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
    test_single_symbol(16'h000B);
  endtask

  initial begin
    test_reset();
    test_single_symbol(16'h0000);
    test_back_to_back();
    test_stall();
    test_random_ack();
    test_partial();
    test_async_reset();
    repeat (2) @(posedge CLK_I);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
